// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl_pkg
//  Description : Shared definitions for the PC / instruction-fetch controller:
//                default reset and exception vectors, and the fetch FSM state
//                encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] PC_STEP            = 32'd4;

    // FETCH: request outstanding to imem for pc_q.
    // HOLD : word for pc_q already captured in the skid buffer, waiting on stall.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage : pc_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl_if
//  Description : Instruction-memory fetch bus.
//                req   - fetch request valid           (master -> slave)
//                addr  - fetch address                 (master -> slave)
//                ready - rdata valid for addr this cycle (slave -> master)
//                rdata - instruction word              (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface : pc_fetch_ctrl_if
`default_nettype wire

// File: rtl/pc_fetch_ctrl_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl_skid_buf
//  Description : One-entry instruction skid buffer. Captures a fetched word
//                that arrives while the pipeline is stalled so imem does not
//                have to be re-requested.
//  Ports       : clk, reset   - clock, asynchronous active-high reset
//                load         - capture din, set full
//                drain        - word consumed, clear full
//                flush        - discard contents (highest priority)
//                din / dout   - 32-bit word in / buffered word out
//                full         - dout holds a valid word
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl_skid_buf (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        load,
    input  wire logic        drain,
    input  wire logic        flush,
    input  wire logic [31:0] din,
    output logic      [31:0] dout,
    output logic             full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= 32'd0;
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule : pc_fetch_ctrl_skid_buf
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Owns the PC register, issues instruction fetches over the
//                imem bus and loads the IF/ID register. Applies hazard stall,
//                exception entry and eret; latches an ID-stage control
//                transfer until the PC next advances (branch delay slot).
//  Ports       : clk, reset            - clock, asynchronous active-high reset
//                stall                 - hold IF/ID and PC
//                npc_sel / npc_in      - ID control transfer pulse / target
//                exc_req               - exception: flush, PC <= EXC_VECTOR
//                eret_req / epc_in     - return: flush, PC <= epc_in
//                imem                  - fetch bus (master side)
//                if_id_ir/pc/pc4/valid - IF/ID pipeline register
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            stall,
    input  wire logic            npc_sel,
    input  wire logic [31:0]     npc_in,
    input  wire logic            exc_req,
    input  wire logic            eret_req,
    input  wire logic [31:0]     epc_in,
    pc_fetch_ctrl_if.master      imem,
    output logic      [31:0]     if_id_ir,
    output logic      [31:0]     if_id_pc,
    output logic      [31:0]     if_id_pc4,
    output logic                 if_id_valid
);

    fetch_state_e state_q, state_next;
    logic [31:0]  pc_q, pc_next;
    logic         pend_vld, pend_vld_next;
    logic [31:0]  pend_pc, pend_pc_next;
    logic [31:0]  ir_next, ifpc_next, ifpc4_next;
    logic         valid_next;

    logic         in_fetch;
    logic         adv;
    logic         redirect;
    logic         buf_load, buf_drain;
    logic [31:0]  buf_data;
    logic         buf_full;
    logic [31:0]  word;
    logic [31:0]  pc_plus4;

    pc_fetch_ctrl_skid_buf u_skid_buf (
        .clk   (clk),
        .reset (reset),
        .load  (buf_load),
        .drain (buf_drain),
        .flush (redirect),
        .din   (imem.rdata),
        .dout  (buf_data),
        .full  (buf_full)
    );

    // The request is gated by reset so it drops the instant reset asserts,
    // not at the next edge; imem must tolerate the abandoned request.
    assign imem.req  = (state_q == FETCH) && !reset;
    assign imem.addr = pc_q;

    assign in_fetch = (state_q == FETCH);
    assign adv      = (in_fetch && imem.ready && !stall) || (!in_fetch && !stall);
    assign redirect = exc_req || eret_req;
    assign pc_plus4 = pc_q + PC_STEP;
    // The buffer is full exactly while in HOLD, so it selects the word source.
    assign word     = buf_full ? buf_data : imem.rdata;

    always_comb begin
        state_next    = state_q;
        pc_next       = pc_q;
        pend_vld_next = pend_vld;
        pend_pc_next  = pend_pc;
        ir_next       = if_id_ir;
        ifpc_next     = if_id_pc;
        ifpc4_next    = if_id_pc4;
        valid_next    = if_id_valid;
        buf_load      = 1'b0;
        buf_drain     = 1'b0;

        if (redirect) begin
            // Exception entry / return override stall and discard any word
            // in flight or buffered; exc_req wins when both are raised.
            pc_next       = exc_req ? EXC_VECTOR : epc_in;
            valid_next    = 1'b0;
            pend_vld_next = 1'b0;
            state_next    = FETCH;
        end else if (adv) begin
            ir_next       = word;
            ifpc_next     = pc_q;
            ifpc4_next    = pc_plus4;
            valid_next    = 1'b1;
            // A transfer latched earlier (delay slot was still fetching)
            // takes precedence over a fresh one this cycle.
            pc_next       = pend_vld ? pend_pc : (npc_sel ? npc_in : pc_plus4);
            pend_vld_next = 1'b0;
            state_next    = FETCH;
            buf_drain     = 1'b1;
        end else begin
            if (in_fetch && imem.ready && stall) begin
                buf_load   = 1'b1;
                state_next = HOLD;
            end
            if (in_fetch && !imem.ready && !stall) begin
                valid_next = 1'b0;
            end
            // Remember the transfer until the delay-slot word is consumed.
            if (npc_sel) begin
                pend_pc_next  = npc_in;
                pend_vld_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            pend_vld    <= 1'b0;
            pend_pc     <= 32'd0;
            if_id_ir    <= 32'd0;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else begin
            state_q     <= state_next;
            pc_q        <= pc_next;
            pend_vld    <= pend_vld_next;
            pend_pc     <= pend_pc_next;
            if_id_ir    <= ir_next;
            if_id_pc    <= ifpc_next;
            if_id_pc4   <= ifpc4_next;
            if_id_valid <= valid_next;
        end
    end

endmodule : pc_fetch_ctrl
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Self-checking bench for pc_fetch_ctrl. Each stimulus cycle
//                pushes the expected IF/ID contents to a scoreboard queue;
//                the entry is popped and compared after the clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam int K_LOAD = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        npc_sel = 1'b0;
    logic [31:0] npc_in = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc_in = 32'd0;
    logic        ready_drv = 1'b0;
    logic [31:0] if_id_ir, if_id_pc, if_id_pc4;
    logic        if_id_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t last_exp = '0;

    pc_fetch_ctrl_if imem_bus ();

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_bus.ready = ready_drv;
    assign imem_bus.rdata = ready_drv ? imem_word(imem_bus.addr) : 32'hDEAD_BEEF;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_sel     (npc_sel),
        .npc_in      (npc_in),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .epc_in      (epc_in),
        .imem        (imem_bus.master),
        .if_id_ir    (if_id_ir),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Asserts reset away from the active edge and checks the outputs clear
    // before any rising edge occurs.
    task automatic reset_dut();
        @(negedge clk);
        reset     = 1'b1;
        ready_drv = 1'b0;
        stall     = 1'b0;
        npc_sel   = 1'b0;
        exc_req   = 1'b0;
        eret_req  = 1'b0;
        #1;
        check("rst_req",   {31'd0, imem_bus.req}, 32'd0);
        check("rst_addr",  imem_bus.addr, 32'h0000_3000);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_ir",    if_id_ir,  32'd0);
        check("rst_pc",    if_id_pc,  32'd0);
        check("rst_pc4",   if_id_pc4, 32'd0);
        sb.delete();
        last_exp = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cyc(input logic rdy, input logic stl, input logic nsel,
                       input logic [31:0] ntgt, input logic exc, input logic eret,
                       input logic [31:0] epc, input logic exp_req,
                       input logic [31:0] exp_addr, input int kind);
        exp_t e;
        @(negedge clk);
        ready_drv = rdy;
        stall     = stl;
        npc_sel   = nsel;
        npc_in    = ntgt;
        exc_req   = exc;
        eret_req  = eret;
        epc_in    = epc;
        #1;
        check("imem_req",  {31'd0, imem_bus.req}, {31'd0, exp_req});
        check("imem_addr", imem_bus.addr, exp_addr);
        case (kind)
            K_LOAD:  e = '{valid: 1'b1, pc: exp_addr, ir: imem_word(exp_addr)};
            K_BUB:   e = '{valid: 1'b0, pc: 32'd0, ir: 32'd0};
            default: e = last_exp;
        endcase
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        if (e.valid) begin
            check("if_id_pc",  if_id_pc,  e.pc);
            check("if_id_pc4", if_id_pc4, e.pc + 32'd4);
            check("if_id_ir",  if_id_ir,  e.ir);
        end
    endtask

    initial begin
        // T1: free-running fetch
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3000, K_LOAD);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3004, K_LOAD);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3008, K_LOAD);

        // T2: imem not ready for 3 cycles at 3004
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3000, K_LOAD);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3004, K_BUB);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3004, K_BUB);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3004, K_BUB);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3004, K_LOAD);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3008, K_BUB);

        // T3: branch with delay slot still waiting on imem
        reset_dut();
        cyc(1, 0, 0, 0,            0, 0, 0, 1, 32'h3000, K_LOAD);
        cyc(0, 0, 1, 32'h3100,     0, 0, 0, 1, 32'h3004, K_BUB);
        cyc(0, 0, 0, 0,            0, 0, 0, 1, 32'h3004, K_BUB);
        cyc(1, 0, 0, 0,            0, 0, 0, 1, 32'h3004, K_LOAD);
        cyc(1, 0, 0, 0,            0, 0, 0, 1, 32'h3100, K_LOAD);
        cyc(0, 0, 0, 0,            0, 0, 0, 1, 32'h3104, K_BUB);

        // T4: stall while the word arrives -> HOLD, release drains buffer
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3000, K_LOAD);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3004, K_LOAD);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 32'h3008, K_HOLD);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 32'h3008, K_HOLD);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, K_LOAD);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h300C, K_BUB);

        // T5: exception during stall + HOLD with a pending transfer
        reset_dut();
        cyc(1, 0, 0, 0,        0, 0, 0, 1, 32'h3000, K_LOAD);
        cyc(1, 0, 0, 0,        0, 0, 0, 1, 32'h3004, K_LOAD);
        cyc(1, 1, 1, 32'h3300, 0, 0, 0, 1, 32'h3008, K_HOLD);
        cyc(0, 1, 0, 0,        1, 0, 0, 0, 32'h3008, K_BUB);
        cyc(1, 0, 0, 0,        0, 0, 0, 1, 32'h4180, K_LOAD);
        cyc(0, 0, 0, 0,        0, 0, 0, 1, 32'h4184, K_BUB);

        // T6: exc+eret together, eret alone, eret to top of address space
        cyc(1, 0, 0, 0, 1, 1, 32'h3200,      1, 32'h4184,      K_BUB);
        cyc(0, 0, 0, 0, 0, 1, 32'h3200,      1, 32'h4180,      K_BUB);
        cyc(1, 0, 0, 0, 0, 0, 0,             1, 32'h3200,      K_LOAD);
        cyc(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h3204,      K_BUB);
        cyc(1, 0, 0, 0, 0, 0, 0,             1, 32'hFFFF_FFFC, K_LOAD);
        cyc(0, 0, 0, 0, 0, 0, 0,             1, 32'h0000_0000, K_BUB);

        // T7: reset asserted while in HOLD
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3000, K_LOAD);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 32'h3004, K_HOLD);
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3000, K_LOAD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_ctrl
`default_nettype wire
